clock_div_bank: RTL and testbench
=================================

Name: clock_div_bank

Overview:
Multi-channel, parametrised successor to the single fixed beat divider. It generates NUM_CH independent strobe streams from clk, each with a programmable period, periodic or one-shot mode and a 50%-duty square output. Rate changes are glitch-free, and channels can be phase-aligned. The block feeds pixel/line timing and slow housekeeping ticks in the VGA datapath.

Parameters:
NUM_CH, 4, number of independent divider channels (1..16)
WIDTH, 18, counter and divisor width in bits
RESET_DIV, 18'h10, active divisor loaded into every channel at reset
CH_W, $clog2(NUM_CH) (min 1), channel-select width (derived, not overridden)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  NUM_CH  per-channel run enable, level-sensitive
sync_clr  in  1  clears all counters to 0 on the same edge (phase align)
cfg_we  in  1  configuration write strobe, single cycle
cfg_ch  in  CH_W  target channel of the write
cfg_div  in  WIDTH  divisor D; channel period = D+1 clk cycles
cfg_oneshot  in  1  1 = one-shot mode, 0 = periodic mode
beat  out  NUM_CH  one-cycle strobe per channel at terminal count
sq  out  NUM_CH  square output, toggles at each beat
busy  out  NUM_CH  channel enabled and not halted in one-shot mode

Behaviour:
- Reset (reset_n low, asynchronous): cnt=0, active div=RESET_DIV, shadow div=RESET_DIV, oneshot=0, done=0, beat=0, sq=0, busy=0. All outputs are registered.
- Per channel, per edge, in priority order:
  1. enable low: cnt<=0, beat<=0, done<=0, sq holds; shadow is copied to active immediately.
  2. sync_clr high: cnt<=0, beat<=0; sq and done hold.
  3. done=1 (one-shot already fired): cnt holds at 0, beat<=0.
  4. cnt==active div (terminal count): cnt<=0, beat<=1, sq<=~sq, shadow is copied to active, done<=oneshot.
  5. otherwise: cnt<=cnt+1, beat<=0.
- Latency: cnt starts at 0 and enable is first sampled high at edge k. beat is first high in the cycle after edge k+D, then every D+1 cycles. D=0 gives beat high every cycle while enabled; sq then toggles every cycle.
- sq period = 2*(D+1) cycles at 50% duty.
- Config write: cfg_we writes cfg_div and cfg_oneshot into channel cfg_ch's shadow. A write with cfg_ch >= NUM_CH is ignored.
- The active divisor never changes mid-period. The shadow transfers only at terminal count or while disabled.
- Write on the same edge as terminal count or while disabled: the new value bypasses the shadow and becomes active on that edge.
- D below the current cnt cannot occur, because the active divisor only changes while cnt is 0.
- busy = enable & ~done, registered.
- One-shot: exactly one beat per enable assertion. Re-arming requires enable low for at least 1 cycle.
- Counter arithmetic is WIDTH bits unsigned. cnt never exceeds the active div, so there is no wrap beyond the terminal count.
- reset_n asserted mid-period: all state clears immediately. The first beat after release follows the latency rule with D=RESET_DIV.
- A single cfg_we pulse touches only one channel. The other channels are unaffected.

Decomposition:
- Shared package clock_div_pkg: WIDTH default, RESET_DIV default, and a channel-config struct {div[WIDTH], oneshot}.
- Sub-module clock_div_channel: one counter, shadow/active registers and the priority logic above.
- Top-level clock_div_bank: instantiates NUM_CH channels via generate, decodes cfg_ch into per-channel write enables, and fans out sync_clr.

Test Plan:
- Reset default: release reset_n, enable[0]=1 at edge k -> beat[0] pulses at edges k+16, k+33, k+50 (period 17). sq[0] toggles at each of those edges.
- Divisor change mid-period: write D=3 to ch1 while cnt=5 and active D=9 -> the current period still completes at cnt 9. The following beats arrive every 4 cycles. No short or merged pulse.
- D=0 and one-shot: ch2 D=0 periodic -> beat[2] constant 1 while enabled. Then write D=2 one-shot and re-enable -> exactly one beat 3 cycles later, after which busy[2]=0. Dropping enable for one cycle re-arms -> one more beat.
- sync_clr alignment: ch0 D=4 and ch3 D=9 running out of phase; pulse sync_clr -> ch0 beats 5 and 10 cycles later, ch3 beats 10 cycles later, and the two coincide.
- Invalid and simultaneous writes: cfg_ch=NUM_CH gives no state change on any channel. A write landing on the terminal-count edge takes effect that edge, so the next period equals the new D+1.
- Async reset mid-count: drop reset_n between clock edges -> beat, sq and busy go to 0 without waiting for a clock edge. The active divisor returns to RESET_DIV.

Source files
------------

// File: rtl/clock_div_pkg.sv
// ----------------------------------------------------------------------------
// clock_div_pkg
// Shared defaults and types for the clock divider bank.
//   DEF_NUM_CH     default number of divider channels
//   DEF_WIDTH      default counter / divisor width
//   DEF_RESET_DIV  divisor every channel runs with after reset
//   ch_cfg_t       one channel's configuration at the default width
//   ch_width()     channel-select width for a given channel count (min 1)
// ----------------------------------------------------------------------------
package clock_div_pkg;

  localparam int DEF_NUM_CH = 4;
  localparam int DEF_WIDTH  = 18;
  localparam logic [DEF_WIDTH-1:0] DEF_RESET_DIV = 18'h10;

  typedef struct packed {
    logic [DEF_WIDTH-1:0] div;
    logic                 oneshot;
  } ch_cfg_t;

  // A single channel still needs a 1-bit select so the port never collapses
  // to zero width.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clock_div_bank_if.sv
// ----------------------------------------------------------------------------
// clock_div_bank_if
// Control and strobe bundle of the clock divider bank.
//   enable       per-channel run enable (level)
//   sync_clr     phase-align pulse, clears every counter
//   cfg_we       single-cycle configuration write strobe
//   cfg_ch       target channel of the write
//   cfg_div      divisor D (period = D+1 clocks)
//   cfg_oneshot  1 = one-shot, 0 = periodic
//   beat         per-channel terminal-count strobe
//   sq           per-channel 50% square wave
//   busy         per-channel enabled and not halted in one-shot
// master drives the controls, slave is the divider bank.
// ----------------------------------------------------------------------------
interface clock_div_bank_if
  import clock_div_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int WIDTH  = DEF_WIDTH
);

  localparam int CH_W = ch_width(NUM_CH);

  logic [NUM_CH-1:0] enable;
  logic              sync_clr;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [WIDTH-1:0]  cfg_div;
  logic              cfg_oneshot;
  logic [NUM_CH-1:0] beat;
  logic [NUM_CH-1:0] sq;
  logic [NUM_CH-1:0] busy;

  modport master (
    output enable, sync_clr, cfg_we, cfg_ch, cfg_div, cfg_oneshot,
    input  beat, sq, busy
  );

  modport slave (
    input  enable, sync_clr, cfg_we, cfg_ch, cfg_div, cfg_oneshot,
    output beat, sq, busy
  );

endinterface

// File: rtl/clock_div_channel.sv
// ----------------------------------------------------------------------------
// clock_div_channel
// One divider channel: counter, shadow/active divisor registers and the
// enable > sync_clr > done > terminal > count priority chain.
//   clk, reset_n   clock and asynchronous active-low reset
//   en             run enable (level)
//   sync_clr       clears the counter (phase align)
//   we             write strobe already decoded for this channel
//   wdiv, woneshot value written into the shadow
//   beat, sq, busy registered outputs
// ----------------------------------------------------------------------------
module clock_div_channel
  import clock_div_pkg::*;
#(
  parameter int               WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_DIV = WIDTH'(DEF_RESET_DIV)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             we,
  input  logic [WIDTH-1:0] wdiv,
  input  logic             woneshot,
  output logic             beat,
  output logic             sq,
  output logic             busy
);

  typedef struct packed {
    logic [WIDTH-1:0] div;
    logic             oneshot;
  } cfg_t;

  logic [WIDTH-1:0] cnt_q,  cnt_d;
  cfg_t             act_q,  act_d;
  cfg_t             shd_q,  shd_d;
  cfg_t             shd_in;
  logic             done_q, done_d;
  logic             beat_q, beat_d;
  logic             sq_q,   sq_d;
  logic             busy_q, busy_d;
  logic             terminal;

  // NOTE: defaults are assigned before any branch so every path writes every
  // variable; a missing default here would infer a latch.
  always_comb begin
    // A write on this edge is visible to the shadow->active transfer on the
    // same edge, so a write landing on terminal count or while disabled
    // takes effect immediately.
    shd_in.div     = we ? wdiv     : shd_q.div;
    shd_in.oneshot = we ? woneshot : shd_q.oneshot;

    terminal = (cnt_q == act_q.div);

    cnt_d  = cnt_q;
    act_d  = act_q;
    shd_d  = shd_in;
    done_d = done_q;
    beat_d = 1'b0;
    sq_d   = sq_q;

    if (!en) begin
      cnt_d  = '0;
      done_d = 1'b0;
      act_d  = shd_in;
    end else if (sync_clr) begin
      cnt_d = '0;
    end else if (done_q) begin
      cnt_d = '0;
    end else if (terminal) begin
      cnt_d  = '0;
      beat_d = 1'b1;
      sq_d   = ~sq_q;
      act_d  = shd_in;
      // The mode of the period that just ended decides whether we halt.
      done_d = act_q.oneshot;
    end else begin
      cnt_d = cnt_q + WIDTH'(1);
    end

    busy_d = en & ~done_d;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      act_q  <= '{div: RESET_DIV, oneshot: 1'b0};
      shd_q  <= '{div: RESET_DIV, oneshot: 1'b0};
      done_q <= 1'b0;
      beat_q <= 1'b0;
      sq_q   <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      act_q  <= act_d;
      shd_q  <= shd_d;
      done_q <= done_d;
      beat_q <= beat_d;
      sq_q   <= sq_d;
      busy_q <= busy_d;
    end
  end

  assign beat = beat_q;
  assign sq   = sq_q;
  assign busy = busy_q;

endmodule

// File: rtl/clock_div_bank.sv
// ----------------------------------------------------------------------------
// clock_div_bank
// NUM_CH independent programmable strobe generators sharing one clock.
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      clock_div_bank_if.slave: enables, sync_clr, config write port,
//            beat / sq / busy outputs (all registered)
// cfg_ch is decoded into one write enable per channel; selects at or above
// NUM_CH match no channel and are dropped.
// ----------------------------------------------------------------------------
module clock_div_bank
  import clock_div_pkg::*;
#(
  parameter int               NUM_CH    = DEF_NUM_CH,
  parameter int               WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_DIV = WIDTH'(DEF_RESET_DIV)
) (
  input  logic             clk,
  input  logic             reset_n,
  clock_div_bank_if.slave  bus
);

  localparam int CH_W = ch_width(NUM_CH);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic ch_we;

    assign ch_we = bus.cfg_we && (bus.cfg_ch == CH_W'(i));

    clock_div_channel #(
      .WIDTH     (WIDTH),
      .RESET_DIV (RESET_DIV)
    ) u_ch (
      .clk      (clk),
      .reset_n  (reset_n),
      .en       (bus.enable[i]),
      .sync_clr (bus.sync_clr),
      .we       (ch_we),
      .wdiv     (bus.cfg_div),
      .woneshot (bus.cfg_oneshot),
      .beat     (bus.beat[i]),
      .sq       (bus.sq[i]),
      .busy     (bus.busy[i])
    );
  end

endmodule

// File: tb/tb_clock_div_bank.sv
// ----------------------------------------------------------------------------
// tb_clock_div_bank
// Expected beat edges are queued as stimulus is applied; a negedge monitor
// compares beat and sq of every channel against the queue each cycle.
// Edge numbering: edge_n counts rising edges; the outputs seen at the falling
// edge that follows rising edge n belong to edge n.
// ----------------------------------------------------------------------------
module tb_clock_div_bank;
  import clock_div_pkg::*;

  localparam int NUM_CH = 5;   // 5 channels so cfg_ch == NUM_CH is encodable
  localparam int WIDTH  = 18;
  localparam int CH_W   = ch_width(NUM_CH);

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  clock_div_bank_if #(.NUM_CH(NUM_CH), .WIDTH(WIDTH)) bus ();

  clock_div_bank #(
    .NUM_CH    (NUM_CH),
    .WIDTH     (WIDTH),
    .RESET_DIV (18'h10)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int edge_n   = 0;
  bit mon_on   = 1'b0;

  typedef struct {
    int ch;
    int e;
  } exp_t;

  exp_t              sb[$];
  logic [NUM_CH-1:0] exp_beat;
  logic [NUM_CH-1:0] sq_exp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int ch, input int e);
    exp_t t;
    t.ch = ch;
    t.e  = e;
    sb.push_back(t);
  endtask

  task automatic at_edge(input int e);
    while (edge_n < e) @(negedge clk);
  endtask

  function automatic ch_cfg_t mk_cfg(input int d, input bit os);
    ch_cfg_t c;
    c.div     = DEF_WIDTH'(d);
    c.oneshot = os;
    return c;
  endfunction

  // Write lands on the next rising edge; returns at the falling edge after it.
  task automatic cfg_write(input int ch, input ch_cfg_t cfg);
    @(negedge clk);
    bus.cfg_we      = 1'b1;
    bus.cfg_ch      = CH_W'(ch);
    bus.cfg_div     = cfg.div;
    bus.cfg_oneshot = cfg.oneshot;
    @(negedge clk);
    bus.cfg_we = 1'b0;
  endtask

  always @(posedge clk) edge_n++;

  // Scoreboard monitor: every cycle, beat must match the queued edges and sq
  // must have toggled once per expected beat.
  always @(negedge clk) begin
    if (!reset_n) begin
      sq_exp = '0;
    end else if (mon_on) begin
      exp_beat = '0;
      for (int j = sb.size() - 1; j >= 0; j--) begin
        if (sb[j].e <= edge_n) begin
          if (sb[j].e == edge_n) exp_beat[sb[j].ch] = 1'b1;
          sb.delete(j);
        end
      end
      sq_exp = sq_exp ^ exp_beat;
      check($sformatf("beat@%0d", edge_n), 32'(bus.beat), 32'(exp_beat));
      check($sformatf("sq@%0d", edge_n), 32'(bus.sq), 32'(sq_exp));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, k2, k3, s;

    bus.enable      = '0;
    bus.sync_clr    = 1'b0;
    bus.cfg_we      = 1'b0;
    bus.cfg_ch      = '0;
    bus.cfg_div     = '0;
    bus.cfg_oneshot = 1'b0;
    reset_n         = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_beat", 32'(bus.beat), 32'd0);
    check("rst_sq",   32'(bus.sq),   32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    mon_on = 1'b1;

    // Reset divisor 16: period 17.
    bus.enable[0] = 1'b1;
    k = edge_n + 1;
    push(0, k + 16); push(0, k + 33); push(0, k + 50);
    at_edge(k);
    check("s1_busy", 32'(bus.busy[0]), 32'd1);
    at_edge(k + 50);
    bus.enable[0] = 1'b0;

    // Mid-period divisor change on ch1: 9 -> 3 written while cnt=5.
    cfg_write(1, mk_cfg(9, 1'b0));
    bus.enable[1] = 1'b1;
    k = edge_n + 1;
    push(1, k + 9); push(1, k + 13); push(1, k + 17); push(1, k + 21);
    at_edge(k + 4);
    bus.cfg_we = 1'b1; bus.cfg_ch = CH_W'(1); bus.cfg_div = 18'd3; bus.cfg_oneshot = 1'b0;
    @(negedge clk);
    bus.cfg_we = 1'b0;
    at_edge(k + 21);
    bus.enable[1] = 1'b0;

    // ch2 D=0 periodic: beat every cycle.
    cfg_write(2, mk_cfg(0, 1'b0));
    bus.enable[2] = 1'b1;
    k = edge_n + 1;
    for (int i = 0; i < 8; i++) push(2, k + i);
    at_edge(k + 7);
    bus.enable[2] = 1'b0;

    // ch2 D=2 one-shot, then re-arm with a one-cycle enable drop.
    cfg_write(2, mk_cfg(2, 1'b1));
    bus.enable[2] = 1'b1;
    k2 = edge_n + 1;
    push(2, k2 + 2);
    at_edge(k2 + 1);
    check("os_busy_run", 32'(bus.busy[2]), 32'd1);
    at_edge(k2 + 3);
    check("os_busy_done", 32'(bus.busy[2]), 32'd0);
    at_edge(k2 + 8);
    check("os_busy_hold", 32'(bus.busy[2]), 32'd0);
    bus.enable[2] = 1'b0;
    @(negedge clk);
    bus.enable[2] = 1'b1;
    k3 = edge_n + 1;
    push(2, k3 + 2);
    at_edge(k3 + 1);
    check("rearm_busy", 32'(bus.busy[2]), 32'd1);
    at_edge(k3 + 8);
    check("rearm_done", 32'(bus.busy[2]), 32'd0);
    bus.enable[2] = 1'b0;

    // sync_clr phase alignment: ch0 D=4, ch3 D=9 started 3 cycles apart.
    cfg_write(0, mk_cfg(4, 1'b0));
    cfg_write(3, mk_cfg(9, 1'b0));
    bus.enable[0] = 1'b1;
    k = edge_n + 1;
    push(0, k + 4);
    at_edge(k + 2);
    bus.enable[3] = 1'b1;
    s = k + 7;
    at_edge(s - 1);
    bus.sync_clr = 1'b1;
    push(0, s + 5); push(0, s + 10); push(3, s + 10);
    @(negedge clk);
    bus.sync_clr = 1'b0;
    at_edge(s + 10);
    check("sync_coincide", 32'(bus.beat[0] & bus.beat[3]), 32'd1);
    bus.enable[0] = 1'b0;
    bus.enable[3] = 1'b0;

    // Writes to cfg_ch >= NUM_CH are dropped: ch0 keeps D=4, ch4 keeps 16.
    cfg_write(NUM_CH, mk_cfg(1, 1'b1));
    cfg_write(7, mk_cfg(1, 1'b1));
    bus.enable[0] = 1'b1;
    bus.enable[4] = 1'b1;
    k = edge_n + 1;
    push(0, k + 4); push(0, k + 9); push(0, k + 14); push(4, k + 16);
    at_edge(k + 16);
    check("inv_busy4", 32'(bus.busy[4]), 32'd1);
    bus.enable[0] = 1'b0;
    bus.enable[4] = 1'b0;

    // Write on the terminal-count edge of ch1 (D=3 -> 6) applies at once.
    bus.enable[1] = 1'b1;
    k = edge_n + 1;
    push(1, k + 3); push(1, k + 10); push(1, k + 17);
    at_edge(k + 2);
    bus.cfg_we = 1'b1; bus.cfg_ch = CH_W'(1); bus.cfg_div = 18'd6; bus.cfg_oneshot = 1'b0;
    @(negedge clk);
    bus.cfg_we = 1'b0;
    at_edge(k + 17);
    bus.enable[1] = 1'b0;

    // Async reset between edges while ch0 is beating.
    bus.enable[0] = 1'b1;
    k = edge_n + 1;
    push(0, k + 4);
    at_edge(k + 4);
    check("pre_rst_busy", 32'(bus.busy[0]), 32'd1);
    #2;
    mon_on  = 1'b0;
    reset_n = 1'b0;
    #1;
    check("arst_beat", 32'(bus.beat), 32'd0);
    check("arst_sq",   32'(bus.sq),   32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    bus.enable[0] = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    mon_on = 1'b1;
    bus.enable[0] = 1'b1;
    k = edge_n + 1;
    push(0, k + 16);
    at_edge(k + 17);
    bus.enable[0] = 1'b0;
    at_edge(edge_n + 4);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
